// File: rtl/receiver_calibration.sv
// receiver_calibration: averages 2^AVG_LOG2 frames of the receiver's no-signal
// baseline, index by index, into an accumulator RAM, then streams the averaged
// one-frame table out on AXI-Stream for loading into the compensation memory.
module receiver_calibration #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 1024,
    parameter int AW        = 10,
    parameter int AVG_LOG2  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] tdata_s,
    input  logic          tvalid_s,
    input  logic          tlast_s,
    input  logic          tuser_s,
    output logic          tready_s,
    output logic [DW-1:0] tdata_m,
    output logic          tvalid_m,
    output logic          tlast_m,
    output logic          tuser_m,
    input  logic          tready_m,
    output logic          busy,
    output logic          done,
    output logic          len_err
);
    localparam int                  ACCW       = DW + AVG_LOG2;
    localparam logic [AW-1:0]       LAST_IDX   = AW'(FRAME_LEN - 1);
    localparam logic [AVG_LOG2-1:0] LAST_FRAME = '1;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACCUM, S_DUMP} state_t;

    function automatic logic signed [ACCW-1:0] sext(input logic signed [DW-1:0] s);
        return {{AVG_LOG2{s[DW-1]}}, s};
    endfunction

    // Arithmetic shift gives floor division; the average always fits in DW bits.
    function automatic logic signed [DW-1:0] avg_floor(input logic signed [ACCW-1:0] acc);
        return DW'(acc >>> AVG_LOG2);
    endfunction

    state_t                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [AVG_LOG2-1:0]    frame_q, frame_d;
    logic [AW:0]            dump_cnt_q, dump_cnt_d;
    logic                   len_err_q, len_err_d;
    logic                   done_q, done_d;
    logic                   rdy_q;

    logic                   vld_p1_q;
    logic [AW-1:0]          addr_p1_q;
    logic signed [DW-1:0]   smp_p1_q;
    logic                   first_p1_q;
    logic signed [ACCW-1:0] mem [FRAME_LEN];
    logic signed [ACCW-1:0] rd_data_p1_q;
    logic signed [ACCW-1:0] wr_data_p1;
    logic [AW-1:0]          rd_addr;

    logic                   rd_vld_p1_q;
    logic [AW-1:0]          rd_idx_p1_q;
    logic [1:0]             cnt_q, cnt_d;
    logic [DW+1:0]          slot0_q, slot0_d, slot1_q, slot1_d;
    logic [DW+1:0]          new_slot;

    logic                   accum_beat, beat_err, beat_ok;
    logic                   push, pop, rd_issue;
    logic [2:0]             occ;

    // The tuser beat seen in SYNC is treated exactly like an ACCUM beat at idx 0.
    assign accum_beat = tvalid_s && ((state_q == S_ACCUM) || ((state_q == S_SYNC) && tuser_s));
    assign beat_err   = accum_beat && ((tlast_s != (idx_q == LAST_IDX)) || (tuser_s && (idx_q != '0)));
    assign beat_ok    = accum_beat && !beat_err;

    // Reads are issued only when the two output slots plus the read in flight
    // leave room, so a stalled consumer never loses a table entry.
    assign pop      = (cnt_q != 2'd0) && tready_m;
    assign push     = rd_vld_p1_q;
    assign occ      = 3'(cnt_q) + 3'(rd_vld_p1_q);
    assign rd_issue = (state_q == S_DUMP) && !dump_cnt_q[AW] && ((occ < 3'd2) || pop);
    assign rd_addr  = (state_q == S_DUMP) ? dump_cnt_q[AW-1:0] : idx_q;

    // Frame 0 overwrites, so the RAM never needs clearing between runs.
    assign wr_data_p1 = first_p1_q ? sext(smp_p1_q) : rd_data_p1_q + sext(smp_p1_q);
    assign new_slot   = {rd_idx_p1_q == '0, rd_idx_p1_q == LAST_IDX, avg_floor(rd_data_p1_q)};

    // Next-state logic: frame tracking, error detection and dump sequencing.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        dump_cnt_d = dump_cnt_q;
        len_err_d  = len_err_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_err_d = 1'b0;
                    idx_d     = '0;
                    frame_d   = '0;
                    state_d   = S_SYNC;
                end
            end
            S_SYNC, S_ACCUM: begin
                if (beat_err) begin
                    len_err_d = 1'b1;
                    idx_d     = '0;
                    frame_d   = '0;
                    state_d   = S_IDLE;
                end else if (beat_ok) begin
                    state_d = S_ACCUM;
                    idx_d   = idx_q + AW'(1);
                    if (idx_q == LAST_IDX) begin
                        frame_d = frame_q + AVG_LOG2'(1);
                        // The last write lands in the first DUMP cycle, while
                        // the dump is reading idx 0, so no hazard arises.
                        if (frame_q == LAST_FRAME) begin
                            state_d    = S_DUMP;
                            dump_cnt_d = '0;
                        end
                    end
                end
            end
            S_DUMP: begin
                if (rd_issue) dump_cnt_d = dump_cnt_q + (AW+1)'(1);
                if (pop && slot0_q[DW]) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Two-entry output skid buffer; slot 0 drives the master port.
    always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) slot0_d = new_slot;
                else               slot1_d = new_slot;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    slot0_d = new_slot;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = new_slot;
                end
            end
            default: ;
        endcase
    end

    // Control state and output registers, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            frame_q     <= '0;
            dump_cnt_q  <= '0;
            len_err_q   <= 1'b0;
            done_q      <= 1'b0;
            rdy_q       <= 1'b0;
            vld_p1_q    <= 1'b0;
            rd_vld_p1_q <= 1'b0;
            cnt_q       <= '0;
            slot0_q     <= '0;
            slot1_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            dump_cnt_q  <= dump_cnt_d;
            len_err_q   <= len_err_d;
            done_q      <= done_d;
            rdy_q       <= 1'b1;
            vld_p1_q    <= beat_ok;
            rd_vld_p1_q <= rd_issue;
            cnt_q       <= cnt_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
        end
    end

    // ---- stage p0 -> p1: capture accepted sample and its RMW context ----
    always_ff @(posedge clk) begin
        addr_p1_q   <= idx_q;
        smp_p1_q    <= $signed(tdata_s);
        first_p1_q  <= (frame_q == '0);
        rd_idx_p1_q <= dump_cnt_q[AW-1:0];
    end

    // Accumulator RAM: registered read, write one cycle after the read.
    always_ff @(posedge clk) begin
        if (vld_p1_q) mem[addr_p1_q] <= wr_data_p1;
        rd_data_p1_q <= mem[rd_addr];
    end

    assign tready_s = rdy_q;
    assign tdata_m  = slot0_q[DW-1:0];
    assign tlast_m  = slot0_q[DW];
    assign tuser_m  = slot0_q[DW+1];
    assign tvalid_m = (cnt_q != 2'd0);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign len_err  = len_err_q;
endmodule

// File: tb/tb_receiver_calibration.sv
// Directed bench for receiver_calibration with an 8-sample frame averaged over 4 frames.
module tb_receiver_calibration;
    localparam int DW = 16;
    localparam int FL = 8;
    localparam int AW = 3;
    localparam int AL = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] tdata_s = '0;
    logic          tvalid_s = 1'b0;
    logic          tlast_s = 1'b0;
    logic          tuser_s = 1'b0;
    logic          tready_s;
    logic [DW-1:0] tdata_m;
    logic          tvalid_m;
    logic          tlast_m;
    logic          tuser_m;
    logic          tready_m = 1'b1;
    logic          busy;
    logic          done;
    logic          len_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_out;
    int n_done;
    int got_d [16];
    int got_u [16];
    int got_l [16];

    receiver_calibration #(.DW(DW), .FRAME_LEN(FL), .AW(AW), .AVG_LOG2(AL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tlast_s(tlast_s), .tuser_s(tuser_s),
        .tready_s(tready_s),
        .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tlast_m(tlast_m), .tuser_m(tuser_m),
        .tready_m(tready_m),
        .busy(busy), .done(done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [15:0] pat(input int mode, input int k, input int i);
        case (mode)
            0:       return 16'd100;
            1:       return 16'(i + k);
            2:       return 16'd0;
            3:       return (i == 0) ? ((k == 0) ? 16'hFFFD : 16'hFFFE) : 16'd0;
            default: return 16'h8000;
        endcase
    endfunction

    function automatic int expv(input int mode, input int i);
        case (mode)
            0:       return 100;
            1:       return i + 1;
            2:       return 0;
            3:       return (i == 0) ? -3 : 0;
            default: return -32768;
        endcase
    endfunction

    task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
        tdata_s  = d;
        tuser_s  = u;
        tlast_s  = l;
        tvalid_s = 1'b1;
        tick();
        tvalid_s = 1'b0;
        tuser_s  = 1'b0;
        tlast_s  = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int k);
        for (int i = 0; i < FL; i++) send_beat(pat(mode, k, i), i == 0, i == FL - 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Collect the dump; bp=1 applies a 1010 ready pattern and a 5-cycle hold-off.
    task automatic drain(input int bp);
        logic stall_prev;
        int   prev_v;
        n_out      = 0;
        n_done     = 0;
        stall_prev = 1'b0;
        prev_v     = 0;
        for (int c = 0; c < 80 && n_done == 0; c++) begin
            if (bp == 0) tready_m = 1'b1;
            else if (c >= 10 && c < 15) tready_m = 1'b0;
            else tready_m = (c % 2 == 0);
            if (stall_prev) begin
                chk("stall_valid", 32'(tvalid_m), 1);
                chk("stall_stable", 32'({tuser_m, tlast_m, tdata_m}), prev_v);
            end
            if (tvalid_m && tready_m) begin
                if (n_out < 16) begin
                    got_d[n_out] = 32'($signed(tdata_m));
                    got_u[n_out] = 32'(tuser_m);
                    got_l[n_out] = 32'(tlast_m);
                end
                n_out++;
            end
            stall_prev = tvalid_m && !tready_m;
            prev_v     = 32'({tuser_m, tlast_m, tdata_m});
            tick();
            if (done) n_done++;
        end
        tready_m = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done) n_done++;
        end
    endtask

    task automatic check_run(input int mode);
        chk("beats", n_out, FL);
        for (int j = 0; j < FL && j < n_out; j++) begin
            chk($sformatf("m%0d_data%0d", mode, j), got_d[j], expv(mode, j));
            chk($sformatf("m%0d_user%0d", mode, j), got_u[j], (j == 0) ? 1 : 0);
            chk($sformatf("m%0d_last%0d", mode, j), got_l[j], (j == FL - 1) ? 1 : 0);
        end
        chk("done_once", n_done, 1);
        chk("busy_after", 32'(busy), 0);
        chk("tvalid_after", 32'(tvalid_m), 0);
    endtask

    task automatic full_run(input int mode, input int bp);
        pulse_start();
        chk("busy_armed", 32'(busy), 1);
        for (int k = 0; k < 4; k++) send_frame(mode, k);
        drain(bp);
        check_run(mode);
    endtask

    initial begin
        int saw_v;
        int saw_d;
        // Reset values
        tick();
        chk("rst_tready_s", 32'(tready_s), 0);
        chk("rst_tvalid_m", 32'(tvalid_m), 0);
        chk("rst_tdata_m", 32'(tdata_m), 0);
        chk("rst_tuser_tlast", 32'({tuser_m, tlast_m}), 0);
        chk("rst_busy_done", 32'({busy, done}), 0);
        chk("rst_len_err", 32'(len_err), 0);
        reset_n = 1'b1;
        tick();
        chk("idle_tready_s", 32'(tready_s), 1);

        // Scenarios 1-3: constant, ramp, zero overwrite, negative floor, full scale
        full_run(0, 0);
        full_run(1, 0);
        full_run(2, 0);
        full_run(3, 0);
        full_run(4, 0);

        // Scenario 4: traffic before start and before first tuser; start during ACCUM
        send_beat(16'd555, 1'b1, 1'b0);
        chk("idle_ignores_input", 32'(busy), 0);
        pulse_start();
        send_beat(16'd777, 1'b0, 1'b0);
        send_beat(16'd888, 1'b0, 1'b1);
        send_beat(16'd999, 1'b0, 1'b0);
        send_frame(0, 0);
        send_frame(0, 1);
        pulse_start();
        chk("start_in_accum_busy", 32'(busy), 1);
        send_frame(0, 2);
        send_frame(0, 3);
        drain(0);
        check_run(0);

        // Scenario 5: early tlast in frame 2
        pulse_start();
        send_frame(0, 0);
        send_frame(0, 1);
        for (int i = 0; i < 6; i++) send_beat(16'd100, i == 0, i == 5);
        chk("lenerr_set", 32'(len_err), 1);
        chk("lenerr_busy", 32'(busy), 0);
        saw_v = 0;
        saw_d = 0;
        for (int c = 0; c < 12; c++) begin
            if (tvalid_m) saw_v++;
            if (done) saw_d++;
            tick();
        end
        chk("lenerr_no_tvalid", saw_v, 0);
        chk("lenerr_no_done", saw_d, 0);
        chk("lenerr_sticky", 32'(len_err), 1);
        pulse_start();
        chk("lenerr_cleared", 32'(len_err), 0);
        for (int k = 0; k < 4; k++) send_frame(1, k);
        drain(0);
        check_run(1);

        // Scenario 6: output backpressure
        full_run(1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/receiver_calibration.md
Name: receiver_calibration

Overview:
Calibration-side counterpart to receiver compensation. It averages 2^AVG_LOG2 consecutive frames of the receiver's no-signal baseline, sample by sample, into an internal accumulator RAM. It then streams out the averaged per-index table (one frame) on AXI-Stream, to be written into the compensation coefficient memory. It sits on the same sample stream as the compensation block, in parallel with it, and is armed by a start pulse from the control logic.

Parameters:
DW, 16, sample and output width (signed two's complement)
FRAME_LEN, 1024, samples per frame; table depth; power of two, >= 4
AW, 10, index width, log2(FRAME_LEN)
AVG_LOG2, 4, log2 of number of frames averaged (1..8)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle arm pulse
tdata_s  in  DW  input sample, signed
tvalid_s  in  1  input valid
tlast_s  in  1  last sample of frame
tuser_s  in  1  first sample of frame
tready_s  out  1  input ready
tdata_m  out  DW  averaged coefficient, signed
tvalid_m  out  1  output valid
tlast_m  out  1  last coefficient (index FRAME_LEN-1)
tuser_m  out  1  first coefficient (index 0)
tready_m  in  1  output ready
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the table has been fully emitted
len_err  out  1  sticky frame-length error; cleared by start

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE and idx and frame_cnt clear. Accumulator RAM contents are not reset.
- State IDLE: tready_s=1 and input is discarded. A start pulse clears len_err and moves to SYNC. start outside IDLE is ignored.
- State SYNC: tready_s=1 and input is discarded until a beat with tvalid_s&&tuser_s. That beat is taken as idx 0 of frame 0 and the FSM enters ACCUM.
- State ACCUM: tready_s=1. Each accepted beat does a read-modify-write at acc[idx].
  - Width of acc is DW+AVG_LOG2, signed.
  - Frame 0 writes the sign-extended sample (no add), so the RAM needs no clear.
  - Frames 1..N-1 write acc[idx]+sample.
  - RMW is pipelined (registered RAM read, write one cycle later). A write and a read to the same index never coincide, because the minimum same-index spacing is FRAME_LEN beats.
- Frame check, on each accepted beat:
  - tlast_s with idx!=FRAME_LEN-1, or idx==FRAME_LEN-1 without tlast_s: len_err<=1, go to IDLE, no output.
  - tuser_s with idx!=0: same error handling.
  - Valid end of frame: idx wraps to 0 and frame_cnt increments. When frame_cnt reaches 2^AVG_LOG2-1 at a valid end of frame, go to DUMP after the final write completes.
- State DUMP: tready_s=1 and input is discarded.
  - RAM is read idx 0..FRAME_LEN-1 into a 2-entry skid/output register, so full throughput is kept under backpressure.
  - tdata_m = acc >>> AVG_LOG2 (arithmetic shift, floor), truncated to the low DW bits. No overflow is possible.
  - tuser_m=1 with idx 0; tlast_m=1 with idx FRAME_LEN-1.
  - tdata_m, tlast_m and tuser_m hold stable while tvalid_m && !tready_m.
  - First tvalid_m appears 2 cycles after entering DUMP. One beat per cycle while tready_m=1.
- After the tlast_m handshake: done=1 for one cycle, tvalid_m=0, state goes to IDLE and busy=0.
- Input backpressure: tready_s never deasserts, so gaps in tvalid_s are the only stall; idx advances only on accepted beats.
- Reset asserted mid-ACCUM or mid-DUMP: immediate IDLE, tvalid_m=0, no done. The next start restarts cleanly because frame 0 overwrites the RAM.

Test Plan:
(Bench uses FRAME_LEN=8, AW=3, AVG_LOG2=2.)
1. start, then 4 frames of constant 100 with tuser/tlast correct -> 8 output beats of 100; tuser_m on beat 0, tlast_m on beat 7; done pulses once; busy low afterwards.
2. Frame k (k=0..3), sample i = i+k -> output i+1 for i=0..7 (floor of (4i+6)/4). Repeat immediately with a new start and all samples 0 -> output all 0, proving the frame-0 overwrite.
3. Index 0 receives -3,-2,-2,-2 across the 4 frames, others 0 -> beat 0 = -3 (floor of -9/4), other beats 0. Full-scale samples -32768 in all frames -> output -32768.
4. Samples with tuser_s=0 arrive before the first tuser_s after start -> ignored; the result matches scenario 1. A start pulse during ACCUM -> no effect.
5. tlast_s at idx 5 in frame 2 -> len_err=1, busy=0, no tvalid_m, no done. Next start clears len_err.
6. tready_m toggled 1010... and held low 5 cycles mid-dump -> all 8 values delivered in order with none dropped or duplicated; data is stable while stalled.
